branch_resolve: RTL and testbench

- ID-stage branch decision unit for the control-hazard pipeline.
- Consumes the equality comparator's `zero` flag for the branch in ID and computes the branch target.
- Stalls the front end until both branch operands are forwardable, then redirects the PC and flushes IF/ID when the branch is taken.
- Sits between the ID-stage comparator and the PC mux / IF-ID register.

---
 rtl/branch_pkg.sv | 31 +++
 rtl/branch_hazard_need.sv | 58 +++++
 rtl/branch_resolve.sv | 166 ++++++++++++++++
 tb/tb_branch_resolve.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared types and constants for the ID-stage branch resolver:
//               branch op encodings, resolver state enum, hazard-need width.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

  // Branch op encodings carried in id_op; 2'b11 is reserved and acts as none.
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;

  // Hazard need ranges 0..2 stall cycles; the stall counter shares this width.
  localparam int NEED_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  // Larger of two per-operand hazard needs.
  function automatic logic [NEED_W-1:0] need_max(input logic [NEED_W-1:0] a,
                                                 input logic [NEED_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_hazard_need.sv
`default_nettype none
// ============================================================================
// Module      : branch_hazard_need
// Description : Combinational count of stall cycles needed before both branch
//               operands can be forwarded to the ID-stage comparator.
//               A load in EX costs 2, an ALU result in EX or a load in MEM
//               costs 1; register 0 is never a hazard.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_hazard_need
  import branch_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [RW-1:0]     rs,
  input  logic [RW-1:0]     rt,
  input  logic              ex_wreg,
  input  logic              ex_m2reg,
  input  logic [RW-1:0]     ex_rd,
  input  logic              mem_wreg,
  input  logic              mem_m2reg,
  input  logic [RW-1:0]     mem_rd,
  output logic [NEED_W-1:0] need
);

  // Stall cycles required for a single source register.
  function automatic logic [NEED_W-1:0] src_need(input logic [RW-1:0] r,
                                                 input logic          e_wreg,
                                                 input logic          e_m2reg,
                                                 input logic [RW-1:0] e_rd,
                                                 input logic          m_wreg,
                                                 input logic          m_m2reg,
                                                 input logic [RW-1:0] m_rd);
    logic [NEED_W-1:0] n;
    n = '0;
    if (r != '0) begin
      if (e_wreg && e_m2reg && (e_rd == r)) begin
        n = NEED_W'(2);
      end else if ((e_wreg && !e_m2reg && (e_rd == r)) ||
                   (m_wreg && m_m2reg && (m_rd == r))) begin
        n = NEED_W'(1);
      end
    end
    return n;
  endfunction

  logic [NEED_W-1:0] need_rs;
  logic [NEED_W-1:0] need_rt;

  // Worst-case need across both branch operands.
  always_comb begin
    need_rs = src_need(rs, ex_wreg, ex_m2reg, ex_rd, mem_wreg, mem_m2reg, mem_rd);
    need_rt = src_need(rt, ex_wreg, ex_m2reg, ex_rd, mem_wreg, mem_m2reg, mem_rd);
    need    = need_max(need_rs, need_rt);
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve
// Description : ID-stage branch decision unit. Stalls the front end until the
//               branch operands are forwardable, then redirects the PC and
//               flushes IF/ID on a taken beq/bne. Target adder is purely
//               combinational.
//               Optional macro BRANCH_STATS_EN adds saturating 32-bit
//               counters n_branch / n_taken / n_stall.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve
  import branch_pkg::*;
#(
  parameter int W  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          id_valid,
  input  logic [1:0]    id_op,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [15:0]   id_imm,
  input  logic [W-1:0]  id_pc4,
  input  logic          zero,
  input  logic          ex_wreg,
  input  logic          ex_m2reg,
  input  logic [RW-1:0] ex_rd,
  input  logic          mem_wreg,
  input  logic          mem_m2reg,
  input  logic [RW-1:0] mem_rd,
  output logic          stall,
  output logic          pc_sel,
  output logic          flush,
  output logic [W-1:0]  br_target
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]   n_branch,
  output logic [31:0]   n_taken,
  output logic [31:0]   n_stall
`endif
);

  state_t            state_q, state_d;
  logic [NEED_W-1:0] cnt_q, cnt_d;
  logic [NEED_W-1:0] need;
  logic              br;
  logic              taken;
  logic              resolve;
  logic              stall_c;
  logic [W-1:0]      imm_ext;

  branch_hazard_need #(
    .RW (RW)
  ) u_need (
    .rs        (id_rs),
    .rt        (id_rt),
    .ex_wreg   (ex_wreg),
    .ex_m2reg  (ex_m2reg),
    .ex_rd     (ex_rd),
    .mem_wreg  (mem_wreg),
    .mem_m2reg (mem_m2reg),
    .mem_rd    (mem_rd),
    .need      (need)
  );

  assign br    = id_valid && ((id_op == BR_BEQ) || (id_op == BR_BNE));
  assign taken = ((id_op == BR_BEQ) && zero) || ((id_op == BR_BNE) && !zero);

  // Branch target: PC+4 plus the sign-extended word offset, wrapping mod 2^W.
  assign imm_ext   = {{(W-16){id_imm[15]}}, id_imm};
  assign br_target = id_pc4 + (imm_ext << 2);

  // State and stall-count registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and decision logic; any loss of the branch in ID aborts quietly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    resolve = 1'b0;
    case (state_q)
      IDLE: begin
        if (br) begin
          if (need == '0) begin
            resolve = 1'b1;
          end else begin
            stall_c = 1'b1;
            cnt_d   = need - NEED_W'(1);
            state_d = (need == NEED_W'(1)) ? RESOLVE : WAIT;
          end
        end
      end
      WAIT: begin
        if (!br) begin
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - NEED_W'(1);
          if (cnt_q == NEED_W'(1)) begin
            state_d = RESOLVE;
          end
        end
      end
      RESOLVE: begin
        state_d = IDLE;
        resolve = br;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs held low while reset is asserted, even with a branch sitting in ID.
  always_comb begin
    stall  = resetn && stall_c;
    pc_sel = resetn && resolve && taken;
    flush  = resetn && resolve && taken;
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] n_branch_q, n_branch_d;
  logic [31:0] n_taken_q,  n_taken_d;
  logic [31:0] n_stall_q,  n_stall_d;

  // Saturating event counters.
  always_comb begin
    n_branch_d = n_branch_q;
    n_taken_d  = n_taken_q;
    n_stall_d  = n_stall_q;
    if (resolve && (n_branch_q != '1)) n_branch_d = n_branch_q + 32'd1;
    if (resolve && taken && (n_taken_q != '1)) n_taken_d = n_taken_q + 32'd1;
    if (stall_c && (n_stall_q != '1)) n_stall_d = n_stall_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      n_branch_q <= '0;
      n_taken_q  <= '0;
      n_stall_q  <= '0;
    end else begin
      n_branch_q <= n_branch_d;
      n_taken_q  <= n_taken_d;
      n_stall_q  <= n_stall_d;
    end
  end

  assign n_branch = n_branch_q;
  assign n_taken  = n_taken_q;
  assign n_stall  = n_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve
// Description : Self-checking bench for branch_resolve: directed scenarios
//               followed by randomized cycles against a behavioural model.
//               Honours BRANCH_STATS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_valid;
  logic [1:0]  id_op;
  logic [4:0]  id_rs, id_rt;
  logic [15:0] id_imm;
  logic [31:0] id_pc4;
  logic        zero;
  logic        ex_wreg, ex_m2reg;
  logic [4:0]  ex_rd;
  logic        mem_wreg, mem_m2reg;
  logic [4:0]  mem_rd;
  logic        stall, pc_sel, flush;
  logic [31:0] br_target;
`ifdef BRANCH_STATS_EN
  logic [31:0] n_branch, n_taken, n_stall;
`endif

  branch_resolve #(.W(32), .RW(5)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .id_valid  (id_valid),
    .id_op     (id_op),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_imm    (id_imm),
    .id_pc4    (id_pc4),
    .zero      (zero),
    .ex_wreg   (ex_wreg),
    .ex_m2reg  (ex_m2reg),
    .ex_rd     (ex_rd),
    .mem_wreg  (mem_wreg),
    .mem_m2reg (mem_m2reg),
    .mem_rd    (mem_rd),
    .stall     (stall),
    .pc_sel    (pc_sel),
    .flush     (flush),
    .br_target (br_target)
`ifdef BRANCH_STATS_EN
    ,
    .n_branch  (n_branch),
    .n_taken   (n_taken),
    .n_stall   (n_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: whether a branch is being held in ID, and how many stall cycles remain
  bit m_busy = 0, nx_busy = 0;
  int m_left = 0, nx_left = 0;
  int c_branch = 0, c_taken = 0, c_stall = 0;
  int nx_branch = 0, nx_taken = 0, nx_stall = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycles a single source register must wait before it can be forwarded.
  function automatic int src_need(input logic [4:0] r);
    int cands[3];
    int best;
    if (r == 5'd0) return 0;
    cands[0] = (ex_wreg && ex_m2reg && ex_rd == r) ? 2 : 0;
    cands[1] = (ex_wreg && !ex_m2reg && ex_rd == r) ? 1 : 0;
    cands[2] = (mem_wreg && mem_m2reg && mem_rd == r) ? 1 : 0;
    best = 0;
    foreach (cands[k]) if (cands[k] > best) best = cands[k];
    return best;
  endfunction

  // Compare DUT outputs against the model for the current inputs.
  task automatic eval();
    bit br, tk, e_st, dec;
    int nd, off;
    logic [31:0] exp_t;
    #1;
    br   = id_valid && (id_op == 2'b01 || id_op == 2'b10);
    tk   = (id_op == 2'b01 && zero) || (id_op == 2'b10 && !zero);
    e_st = 0;
    dec  = 0;
    nx_busy = m_busy;
    nx_left = m_left;
    if (!resetn) begin
      m_busy = 0; m_left = 0; nx_busy = 0; nx_left = 0;
      c_branch = 0; c_taken = 0; c_stall = 0;
    end else if (m_busy) begin
      if (!br) nx_busy = 0;
      else if (m_left > 0) begin e_st = 1; nx_left = m_left - 1; end
      else begin dec = 1; nx_busy = 0; end
    end else if (br) begin
      nd = src_need(id_rs);
      if (src_need(id_rt) > nd) nd = src_need(id_rt);
      if (nd == 0) dec = 1;
      else begin e_st = 1; nx_busy = 1; nx_left = nd - 1; end
    end
    off   = $signed(id_imm);
    exp_t = id_pc4 + 32'(off * 4);
    check("stall",  64'(stall),  64'(e_st));
    check("pc_sel", 64'(pc_sel), 64'(dec && tk));
    check("flush",  64'(flush),  64'(dec && tk));
    check("stall_and_pc_sel", 64'(stall && pc_sel), 64'(0));
    if (dec && tk) check("br_target", 64'(br_target), 64'(exp_t));
`ifdef BRANCH_STATS_EN
    check("n_branch", 64'(n_branch), 64'(c_branch));
    check("n_taken",  64'(n_taken),  64'(c_taken));
    check("n_stall",  64'(n_stall),  64'(c_stall));
`endif
    nx_branch = c_branch + (dec ? 1 : 0);
    nx_taken  = c_taken + ((dec && tk) ? 1 : 0);
    nx_stall  = c_stall + (e_st ? 1 : 0);
    if (!resetn) begin nx_branch = 0; nx_taken = 0; nx_stall = 0; end
  endtask

  // Advance one clock and commit the model's next state.
  task automatic tick();
    @(posedge clk);
    m_busy = nx_busy; m_left = nx_left;
    c_branch = nx_branch; c_taken = nx_taken; c_stall = nx_stall;
    @(negedge clk);
  endtask

  task automatic step();
    eval();
    tick();
  endtask

  task automatic quiet();
    id_valid = 0; id_op = 2'b00; id_rs = 0; id_rt = 0; id_imm = 0; id_pc4 = 0;
    zero = 0; ex_wreg = 0; ex_m2reg = 0; ex_rd = 0;
    mem_wreg = 0; mem_m2reg = 0; mem_rd = 0;
  endtask

  task automatic branch(input logic [1:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [15:0] imm, input logic [31:0] pc4, input logic z);
    id_valid = 1; id_op = op; id_rs = rs; id_rt = rt; id_imm = imm; id_pc4 = pc4; zero = z;
  endtask

  initial begin
    resetn = 1'b0;
    quiet();
    @(negedge clk);

    // Reset state, with a taken no-hazard branch present to show gating.
    branch(2'b01, 5'd1, 5'd2, 16'h0003, 32'h0040_0004, 1'b1);
    step();
    quiet();
    step();
    resetn = 1'b1;
    step();

    // beq no hazard, taken in the same cycle.
    branch(2'b01, 5'd1, 5'd2, 16'h0003, 32'h0040_0004, 1'b1);
    eval();
    check("beq_target_const", 64'(br_target), 64'h0040_0010);
    tick();
    quiet(); step();

    // bne with a load in EX on rs: two stall cycles, then taken.
    branch(2'b10, 5'd8, 5'd3, 16'h0010, 32'h0000_1000, 1'b1);
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 5'd8;
    step();
    ex_wreg = 0; ex_m2reg = 0; ex_rd = 0;
    step();
    zero = 0;
    eval();
    check("bne_load_redirect", 64'(pc_sel), 64'(1));
    tick();
    quiet(); step();

    // beq with ALU result in EX on rt: one stall, then not taken.
    branch(2'b01, 5'd4, 5'd9, 16'h0020, 32'h0000_2000, 1'b0);
    ex_wreg = 1; ex_m2reg = 0; ex_rd = 5'd9;
    step();
    step();
    quiet(); step();

    // r0 never hazards; negative offset wraps the target.
    branch(2'b01, 5'd0, 5'd0, 16'hFFFF, 32'h0000_0000, 1'b1);
    ex_wreg = 1; ex_rd = 5'd0;
    eval();
    check("wrap_target_const", 64'(br_target), 64'hFFFF_FFFC);
    tick();
    quiet(); step();

    // Load in MEM costs one stall.
    branch(2'b10, 5'd5, 5'd6, 16'h0004, 32'h0000_3000, 1'b0);
    mem_wreg = 1; mem_m2reg = 1; mem_rd = 5'd6;
    step(); step();
    quiet(); step();

    // Reset pulsed during WAIT: no redirect afterwards.
    branch(2'b10, 5'd7, 5'd0, 16'h0008, 32'h0000_4000, 1'b0);
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 5'd7;
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    quiet();
    step(); step();

    // Abort: branch disappears from ID mid-stall.
    branch(2'b01, 5'd3, 5'd0, 16'h0001, 32'h0000_5000, 1'b1);
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 5'd3;
    step();
    id_op = 2'b11;
    step();
    quiet(); step();

`ifdef BRANCH_STATS_EN
    // Fresh counters: 3 branches, 2 taken, one with a 2-cycle stall.
    resetn = 1'b0; step(); resetn = 1'b1; step();
    branch(2'b01, 5'd1, 5'd2, 16'h0001, 32'h100, 1'b1); step();
    quiet(); step();
    branch(2'b10, 5'd8, 5'd0, 16'h0001, 32'h200, 1'b0);
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 5'd8;
    step(); step(); step();
    quiet(); step();
    branch(2'b01, 5'd1, 5'd2, 16'h0001, 32'h300, 1'b0); step();
    quiet();
    eval();
    check("stats_branch_const", 64'(n_branch), 64'd3);
    check("stats_taken_const",  64'(n_taken),  64'd2);
    check("stats_stall_const",  64'(n_stall),  64'd2);
    tick();
`endif

    // Randomized cycles; a held branch usually stays put in ID while stalled.
    for (int i = 0; i < 3000; i++) begin
      if (!m_busy || $urandom_range(0, 9) == 0) begin
        id_valid  = ($urandom_range(0, 7) != 0);
        id_op     = 2'($urandom_range(0, 3));
        id_rs     = 5'($urandom_range(0, 3));
        id_rt     = 5'($urandom_range(0, 3));
        id_imm    = 16'($urandom);
        id_pc4    = $urandom;
      end
      zero      = 1'($urandom_range(0, 1));
      ex_wreg   = 1'($urandom_range(0, 1));
      ex_m2reg  = 1'($urandom_range(0, 1));
      ex_rd     = 5'($urandom_range(0, 3));
      mem_wreg  = 1'($urandom_range(0, 1));
      mem_m2reg = 1'($urandom_range(0, 1));
      mem_rd    = 5'($urandom_range(0, 3));
      resetn    = ($urandom_range(0, 59) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
